// File: rtl/ex_mem_lane_arbiter.sv
// Execute-to-memory boundary: squashes lanes younger than the oldest redirect,
// serialises surviving dcache requests in lane order and registers the bundle into mem.

module ex_mem_lane_slot (
    input  logic valid,
    input  logic mem_req,
    input  logic excp,
    input  logic older_redirect,
    output logic survive,
    output logic req
);
    assign survive = valid & ~older_redirect;
    assign req     = survive & mem_req & ~excp;
endmodule

module ex_mem_lane_arbiter #(
    parameter  int LANES     = 4,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int PAYLOAD_W = 128,
    localparam int STRB_W    = DATA_W / 8,
    localparam int IDX_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                pause,
    input  logic [LANES-1:0]                    lane_valid_i,
    input  logic [LANES-1:0][PAYLOAD_W-1:0]     lane_payload_i,
    input  logic [LANES-1:0]                    lane_mem_req_i,
    input  logic [LANES-1:0]                    lane_mem_op_i,
    input  logic [LANES-1:0][ADDR_W-1:0]        lane_vaddr_i,
    input  logic [LANES-1:0][DATA_W-1:0]        lane_wdata_i,
    input  logic [LANES-1:0][STRB_W-1:0]        lane_wstrb_i,
    input  logic [LANES-1:0]                    lane_br_flush_i,
    input  logic [LANES-1:0][ADDR_W-1:0]        lane_br_target_i,
    input  logic [LANES-1:0]                    lane_excp_i,
    output logic                                dc_valid_o,
    output logic                                dc_op_o,
    output logic [ADDR_W-1:0]                   dc_vaddr_o,
    output logic [DATA_W-1:0]                   dc_wdata_o,
    output logic [STRB_W-1:0]                   dc_wstrb_o,
    input  logic                                dc_addr_ok_i,
    output logic                                pause_o,
    output logic                                branch_flush_o,
    output logic [ADDR_W-1:0]                   branch_target_o,
    output logic                                excp_flush_o,
    output logic [LANES-1:0]                    mem_valid_o,
    output logic [LANES-1:0][PAYLOAD_W-1:0]     mem_payload_o,
    output logic                                upd_valid_o,
    output logic [IDX_W-1:0]                    upd_lane_o,
    output logic [ADDR_W-1:0]                   upd_target_o
);
    logic [LANES-1:0] redirect, older, survive, req, pending, served;
    logic [IDX_W-1:0] f_idx, cur;
    logic             has_f, hs, last_req, stage_go;

    assign redirect = lane_valid_i & (lane_br_flush_i | lane_excp_i);
    assign has_f    = |redirect;

    // older[i]: some lane below i redirects, so lane i is squashed
    always_comb begin
        older[0] = 1'b0;
        for (int i = 1; i < LANES; i++)
            older[i] = older[i-1] | redirect[i-1];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ex_mem_lane_slot u_slot (
            .valid          (lane_valid_i[g]),
            .mem_req        (lane_mem_req_i[g]),
            .excp           (lane_excp_i[g]),
            .older_redirect (older[g]),
            .survive        (survive[g]),
            .req            (req[g])
        );
    end

    always_comb begin
        f_idx = '0;
        for (int i = LANES - 1; i >= 0; i--)
            if (redirect[i]) f_idx = IDX_W'(i);
    end

    assign pending = req & ~served;

    always_comb begin
        cur = '0;
        for (int i = LANES - 1; i >= 0; i--)
            if (pending[i]) cur = IDX_W'(i);
    end

    assign last_req   = (pending & (pending - LANES'(1))) == '0;
    assign dc_valid_o = rst & (|pending) & ~pause & ~flush;
    assign hs         = dc_valid_o & dc_addr_ok_i;
    assign pause_o    = rst & (|pending) & ~(hs & last_req);
    assign stage_go   = rst & ~pause_o & ~pause;

    assign dc_op_o    = rst & lane_mem_op_i[cur];
    assign dc_vaddr_o = rst ? lane_vaddr_i[cur] : '0;
    assign dc_wdata_o = rst ? lane_wdata_i[cur] : '0;
    assign dc_wstrb_o = rst ? lane_wstrb_i[cur] : '0;

    // an exception on the redirect lane suppresses its branch redirect
    assign branch_flush_o  = stage_go & has_f & lane_br_flush_i[f_idx] & ~lane_excp_i[f_idx];
    assign excp_flush_o    = stage_go & has_f & lane_excp_i[f_idx];
    assign branch_target_o = rst ? lane_br_target_i[f_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            served <= '0;
        else if (flush || (!pause_o && !pause))
            served <= '0;
        else if (hs)
            served[cur] <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_o   <= '0;
            mem_payload_o <= '0;
        end else if (flush) begin
            mem_valid_o   <= '0;
        end else if (pause_o && !pause) begin
            mem_valid_o   <= '0;
        end else if (!pause) begin
            mem_valid_o   <= survive;
            mem_payload_o <= lane_payload_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid_o  <= 1'b0;
            upd_lane_o   <= '0;
            upd_target_o <= '0;
        end else begin
            upd_valid_o <= branch_flush_o;
            if (branch_flush_o) begin
                upd_lane_o   <= f_idx;
                upd_target_o <= lane_br_target_i[f_idx];
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_lane_arbiter.sv
// Directed bench for ex_mem_lane_arbiter; expectations queue up per bundle and
// monitors retire them as dcache handshakes, redirects, mem loads and BPU updates appear.

module tb_ex_mem_lane_arbiter;
    localparam int LANES = 4, ADDR_W = 32, DATA_W = 32, PAYLOAD_W = 128, SW = DATA_W / 8;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, pause = 1'b0;
    logic [LANES-1:0] lane_valid_i, lane_mem_req_i, lane_mem_op_i, lane_br_flush_i, lane_excp_i;
    logic [LANES-1:0][PAYLOAD_W-1:0] lane_payload_i;
    logic [LANES-1:0][ADDR_W-1:0] lane_vaddr_i, lane_br_target_i;
    logic [LANES-1:0][DATA_W-1:0] lane_wdata_i;
    logic [LANES-1:0][SW-1:0] lane_wstrb_i;
    logic dc_addr_ok_i = 1'b1;
    logic dc_valid_o, dc_op_o, pause_o, branch_flush_o, excp_flush_o, upd_valid_o;
    logic [ADDR_W-1:0] dc_vaddr_o, branch_target_o, upd_target_o;
    logic [DATA_W-1:0] dc_wdata_o;
    logic [SW-1:0] dc_wstrb_o;
    logic [LANES-1:0] mem_valid_o;
    logic [LANES-1:0][PAYLOAD_W-1:0] mem_payload_o;
    logic [1:0] upd_lane_o;

    always #5 clk = ~clk;

    ex_mem_lane_arbiter #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pause(pause),
        .lane_valid_i(lane_valid_i), .lane_payload_i(lane_payload_i),
        .lane_mem_req_i(lane_mem_req_i), .lane_mem_op_i(lane_mem_op_i),
        .lane_vaddr_i(lane_vaddr_i), .lane_wdata_i(lane_wdata_i), .lane_wstrb_i(lane_wstrb_i),
        .lane_br_flush_i(lane_br_flush_i), .lane_br_target_i(lane_br_target_i),
        .lane_excp_i(lane_excp_i),
        .dc_valid_o(dc_valid_o), .dc_op_o(dc_op_o), .dc_vaddr_o(dc_vaddr_o),
        .dc_wdata_o(dc_wdata_o), .dc_wstrb_o(dc_wstrb_o), .dc_addr_ok_i(dc_addr_ok_i),
        .pause_o(pause_o), .branch_flush_o(branch_flush_o), .branch_target_o(branch_target_o),
        .excp_flush_o(excp_flush_o), .mem_valid_o(mem_valid_o), .mem_payload_o(mem_payload_o),
        .upd_valid_o(upd_valid_o), .upd_lane_o(upd_lane_o), .upd_target_o(upd_target_o)
    );

    typedef struct { logic op; logic [31:0] vaddr; logic [31:0] wdata; logic [3:0] wstrb; } dc_exp_t;
    typedef struct { logic [3:0] valid; int b; } mem_exp_t;
    typedef struct { logic excp; logic [31:0] target; } fl_exp_t;
    typedef struct { logic [1:0] lane; logic [31:0] target; } upd_exp_t;

    dc_exp_t  dc_q[$];
    mem_exp_t mem_q[$];
    fl_exp_t  fl_q[$];
    upd_exp_t upd_q[$];
    int checks = 0, passed = 0;
    logic pause_at_edge = 1'b0, prev_bf = 1'b0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endfunction

    function automatic logic [PAYLOAD_W-1:0] pay(input int b, input int i);
        return {32'(b), 32'(i), 64'h0123_4567_89ab_cdef};
    endfunction

    task automatic clear_lanes();
        lane_valid_i = '0; lane_mem_req_i = '0; lane_mem_op_i = '0;
        lane_br_flush_i = '0; lane_excp_i = '0; lane_payload_i = '0;
        lane_vaddr_i = '0; lane_wdata_i = '0; lane_wstrb_i = '0; lane_br_target_i = '0;
    endtask

    task automatic set_payloads(input int b);
        for (int i = 0; i < LANES; i++) lane_payload_i[i] = pay(b, i);
    endtask

    task automatic set_lane(input int i, input logic v, input logic mr, input logic op,
                            input logic [31:0] va, input logic [31:0] wd, input logic [3:0] ws,
                            input logic br, input logic [31:0] tg, input logic ex);
        lane_valid_i[i] = v; lane_mem_req_i[i] = mr; lane_mem_op_i[i] = op;
        lane_vaddr_i[i] = va; lane_wdata_i[i] = wd; lane_wstrb_i[i] = ws;
        lane_br_flush_i[i] = br; lane_br_target_i[i] = tg; lane_excp_i[i] = ex;
    endtask

    // Holds the bundle until the stage completes; addr_ok rises after ok_delay cycles.
    task automatic run_bundle(input int ok_delay, output int stalls, output int dvs, output int bubbles);
        int cyc;
        bit done;
        cyc = 0; done = 1'b0; stalls = 0; dvs = 0; bubbles = 0;
        dc_addr_ok_i = (ok_delay == 0);
        while (!done) begin
            @(negedge clk);
            if (pause_o) stalls++;
            if (dc_valid_o) dvs++;
            if (cyc > 0 && mem_valid_o == '0) bubbles++;
            if (!pause_o && !pause) done = 1'b1;
            else if (cyc == 40) begin
                chk("bundle_timeout", pause_o, 1'b0);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                dc_addr_ok_i = (cyc >= ok_delay);
            end
        end
        @(posedge clk); #1;
        clear_lanes();
        dc_addr_ok_i = 1'b1;
    endtask

    always @(posedge clk) pause_at_edge <= pause;

    always @(negedge clk) begin : mon
        dc_exp_t de;
        mem_exp_t me;
        fl_exp_t fe;
        upd_exp_t ue;
        if (dc_valid_o && dc_addr_ok_i) begin
            if (dc_q.size() == 0) chk("dc_unexpected_req", 0, 1);
            else begin
                de = dc_q.pop_front();
                chk("dc_vaddr", dc_vaddr_o, de.vaddr);
                chk("dc_op", dc_op_o, de.op);
                chk("dc_wdata", dc_wdata_o, de.wdata);
                chk("dc_wstrb", dc_wstrb_o, de.wstrb);
            end
        end
        if (rst && mem_valid_o != '0 && !pause_at_edge) begin
            if (mem_q.size() == 0) chk("mem_unexpected_load", 0, 1);
            else begin
                me = mem_q.pop_front();
                chk("mem_valid", mem_valid_o, me.valid);
                for (int i = 0; i < LANES; i++)
                    if (me.valid[i]) chk("mem_payload", mem_payload_o[i], pay(me.b, i));
            end
        end
        if (branch_flush_o || excp_flush_o) begin
            if (fl_q.size() == 0) chk("redirect_unexpected", 0, 1);
            else begin
                fe = fl_q.pop_front();
                chk("redirect_kind", {branch_flush_o, excp_flush_o}, fe.excp ? 2'b01 : 2'b10);
                if (!fe.excp) chk("branch_target", branch_target_o, fe.target);
            end
        end
        if (upd_valid_o) begin
            if (upd_q.size() == 0) chk("upd_unexpected", 0, 1);
            else begin
                ue = upd_q.pop_front();
                chk("upd_latency", prev_bf, 1'b1);
                chk("upd_lane", upd_lane_o, ue.lane);
                chk("upd_target", upd_target_o, ue.target);
            end
        end
        prev_bf = branch_flush_o;
    end

    initial begin
        int st, dv, bub;
        clear_lanes();
        // reset with a live bundle: combinational outputs must stay low
        set_lane(0, 1, 1, 0, 32'h0000_1000, 32'h0, 4'h0, 0, 32'h0, 0);
        set_lane(1, 1, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0000_2000, 0);
        repeat (2) @(negedge clk);
        chk("rst_dc_valid", dc_valid_o, 1'b0);
        chk("rst_pause_o", pause_o, 1'b0);
        chk("rst_branch_flush", branch_flush_o, 1'b0);
        chk("rst_mem_valid", mem_valid_o, 4'b0);
        chk("rst_upd_valid", upd_valid_o, 1'b0);
        clear_lanes();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // two stores in lanes 1 and 3, serialised back to back
        set_payloads(1);
        set_lane(0, 1, 0, 0, 32'h1000_0000, 32'h0, 4'h0, 0, 32'h0, 0);
        set_lane(1, 1, 1, 1, 32'h1000_0100, 32'hd1d1_d1d1, 4'hf, 0, 32'h0, 0);
        set_lane(2, 1, 0, 0, 32'h1000_0200, 32'h0, 4'h0, 0, 32'h0, 0);
        set_lane(3, 1, 1, 1, 32'h1000_0300, 32'hd3d3_d3d3, 4'h3, 0, 32'h0, 0);
        dc_q.push_back('{1'b1, 32'h1000_0100, 32'hd1d1_d1d1, 4'hf});
        dc_q.push_back('{1'b1, 32'h1000_0300, 32'hd3d3_d3d3, 4'h3});
        mem_q.push_back('{4'b1111, 1});
        run_bundle(0, st, dv, bub);
        chk("t1_stalls", st, 1); chk("t1_dc_cycles", dv, 2); chk("t1_bubbles", bub, 1);

        // lane 1 mispredict squashes lanes 2 and 3 and their requests
        set_payloads(2);
        set_lane(0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);
        set_lane(1, 1, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h1c00_0040, 0);
        set_lane(2, 1, 1, 1, 32'h2000_0200, 32'h22, 4'hf, 0, 32'h0, 0);
        set_lane(3, 1, 1, 0, 32'h2000_0300, 32'h33, 4'hf, 0, 32'h0, 0);
        fl_q.push_back('{1'b0, 32'h1c00_0040});
        mem_q.push_back('{4'b0011, 2});
        upd_q.push_back('{2'd1, 32'h1c00_0040});
        run_bundle(0, st, dv, bub);
        chk("t2_stalls", st, 0); chk("t2_dc_cycles", dv, 0);

        // lane 0 load with dcache refusing for three cycles
        set_payloads(3);
        set_lane(0, 1, 1, 0, 32'h3000_0040, 32'h3333_0000, 4'h0, 0, 32'h0, 0);
        dc_q.push_back('{1'b0, 32'h3000_0040, 32'h3333_0000, 4'h0});
        mem_q.push_back('{4'b0001, 3});
        run_bundle(3, st, dv, bub);
        chk("t3_stalls", st, 3); chk("t3_dc_cycles", dv, 4); chk("t3_bubbles", bub, 3);

        // lane 2 exception (with branch too) never reaches the dcache; exception wins
        set_payloads(4);
        set_lane(0, 1, 1, 0, 32'h4000_0000, 32'h4444_0000, 4'h0, 0, 32'h0, 0);
        set_lane(1, 1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);
        set_lane(2, 1, 1, 1, 32'h4000_0200, 32'h4444_0002, 4'hf, 1, 32'h1c00_0099, 1);
        set_lane(3, 1, 1, 0, 32'h4000_0300, 32'h0, 4'h0, 0, 32'h0, 0);
        dc_q.push_back('{1'b0, 32'h4000_0000, 32'h4444_0000, 4'h0});
        fl_q.push_back('{1'b1, 32'h0});
        mem_q.push_back('{4'b0111, 4});
        run_bundle(0, st, dv, bub);
        chk("t4_stalls", st, 0); chk("t4_dc_cycles", dv, 1);

        // flush between two pending loads, then a new bundle restarts at lane 0
        set_payloads(5);
        set_lane(0, 1, 1, 0, 32'h5000_0000, 32'h5, 4'h0, 0, 32'h0, 0);
        set_lane(2, 1, 1, 0, 32'h5000_0200, 32'h5, 4'h0, 0, 32'h0, 0);
        dc_q.push_back('{1'b0, 32'h5000_0000, 32'h5, 4'h0});
        @(negedge clk);
        chk("t5_pause_pre_flush", pause_o, 1'b1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("t5_dc_valid_flush", dc_valid_o, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t5_mem_flushed", mem_valid_o, 4'b0);
        clear_lanes();
        set_payloads(6);
        set_lane(0, 1, 1, 0, 32'h6000_0000, 32'h6, 4'h0, 0, 32'h0, 0);
        set_lane(2, 1, 1, 0, 32'h6000_0200, 32'h6, 4'h0, 0, 32'h0, 0);
        dc_q.push_back('{1'b0, 32'h6000_0000, 32'h6, 4'h0});
        dc_q.push_back('{1'b0, 32'h6000_0200, 32'h6, 4'h0});
        mem_q.push_back('{4'b0101, 6});
        run_bundle(0, st, dv, bub);
        chk("t5_stalls", st, 1); chk("t5_dc_cycles", dv, 2);

        // complete bundle under downstream pause: redirect held back until pause drops
        set_payloads(7);
        set_lane(0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h1c00_0080, 0);
        set_lane(1, 1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);
        pause = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t6_branch_gated", branch_flush_o, 1'b0);
            chk("t6_no_dc", dc_valid_o, 1'b0);
        end
        @(posedge clk); #1 pause = 1'b0;
        fl_q.push_back('{1'b0, 32'h1c00_0080});
        mem_q.push_back('{4'b0001, 7});
        upd_q.push_back('{2'd0, 32'h1c00_0080});
        run_bundle(0, st, dv, bub);
        chk("t6_stalls", st, 0);

        // stall a load under pause, then assert reset mid-stall
        pause = 1'b1;
        dc_addr_ok_i = 1'b0;
        set_lane(0, 1, 1, 0, 32'h7000_0000, 32'h7, 4'h0, 0, 32'h0, 0);
        @(negedge clk);
        chk("t7_pause_o", pause_o, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; pause = 1'b0; dc_addr_ok_i = 1'b1;
        #1;
        chk("t7_rst_dc_valid", dc_valid_o, 1'b0);
        chk("t7_rst_pause_o", pause_o, 1'b0);
        chk("t7_rst_mem_valid", mem_valid_o, 4'b0);
        chk("t7_rst_upd_target", upd_target_o, 32'h0);
        chk("t7_rst_upd_valid", upd_valid_o, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("t7_rst_hold_dc", dc_valid_o, 1'b0);
        end
        @(posedge clk); #1;
        clear_lanes();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("dc_q_leftover", dc_q.size(), 0);
        chk("mem_q_leftover", mem_q.size(), 0);
        chk("fl_q_leftover", fl_q.size(), 0);
        chk("upd_q_leftover", upd_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_lane_arbiter.md
Name: ex_mem_lane_arbiter

Overview:
- Parametrised N-lane execute-to-memory boundary for the multi-issue core.
- Resolves the oldest redirecting lane (branch mispredict or exception) per bundle and squashes all younger lanes.
- Serialises surviving lanes' memory requests onto the single dcache port in program order, stalling the stage until all are accepted.
- Registers the surviving bundle into the mem stage and produces a registered branch-predictor update.

Parameters:
LANES, 4, issue lanes per bundle; lane 0 is oldest.
ADDR_W, 32, virtual address and branch target width.
DATA_W, 32, store data width; strobe width is DATA_W/8.
PAYLOAD_W, 128, opaque per-lane ex->mem payload width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush  in  1  ctrl flush; kills bundle and any in-progress serialisation
pause  in  1  downstream (mem) stall; hold pipeline register
lane_valid_i  in  LANES  lane carries an instruction
lane_payload_i  in  LANES*PAYLOAD_W  per-lane ex result payload
lane_mem_req_i  in  LANES  lane needs a dcache request
lane_mem_op_i  in  LANES  0 = load, 1 = store
lane_vaddr_i  in  LANES*ADDR_W  per-lane virtual address
lane_wdata_i  in  LANES*DATA_W  per-lane store data
lane_wstrb_i  in  LANES*DATA_W/8  per-lane byte strobes
lane_br_flush_i  in  LANES  lane mispredicted
lane_br_target_i  in  LANES*ADDR_W  corrected target
lane_excp_i  in  LANES  lane raised an exception or needs a refetch
dc_valid_o  out  1  dcache request valid
dc_op_o  out  1  request op
dc_vaddr_o  out  ADDR_W  request address
dc_wdata_o  out  DATA_W  request store data
dc_wstrb_o  out  DATA_W/8  request strobes
dc_addr_ok_i  in  1  dcache accepted request
pause_o  out  1  stage stall to ctrl
branch_flush_o  out  1  redirect fetch
branch_target_o  out  ADDR_W  redirect target
excp_flush_o  out  1  exception redirect request
mem_valid_o  out  LANES  registered surviving-lane valids
mem_payload_o  out  LANES*PAYLOAD_W  registered payloads
upd_valid_o  out  1  registered BPU update pulse
upd_lane_o  out  $clog2(LANES)  lane of the update
upd_target_o  out  ADDR_W  target of the update

Behaviour:
- Redirect lane f: the lowest index with lane_valid_i & (lane_br_flush_i | lane_excp_i). survive[i] = lane_valid_i[i] & (no f, or i <= f).
- Request vector: req = survive & lane_mem_req_i & ~lane_excp_i. An excepting lane never accesses the dcache.
- served register (LANES bits): pending = req & ~served. Current request cur = lowest set bit of pending. dc_* fields are muxed from cur.
- dc_valid_o = |pending & !pause & !flush.
- Handshake: dc_valid_o & dc_addr_ok_i. On a handshake, served[cur] is set at the clock edge.
- pause_o = |pending & !(handshake & popcount(pending)==1). The stall therefore drops in the cycle the last request is accepted.
- served clears on flush, or on bundle completion (!pause_o & !pause). The same rule covers bundles with no requests.
- Upstream holds all lane inputs stable while pause_o or pause is high.
- branch_flush_o = f exists & lane_br_flush_i[f] & !lane_excp_i[f] & !pause_o & !pause. branch_target_o = lane_br_target_i[f].
- excp_flush_o = f exists & lane_excp_i[f] & !pause_o & !pause. Exception wins over branch on the same lane.
- Pipeline register priority, highest first:
  - flush: clear mem_valid_o.
  - pause_o & !pause: clear mem_valid_o (bubble).
  - !pause: mem_valid_o <= survive, mem_payload_o <= lane_payload_i.
  - otherwise hold.
- Squashed lanes may keep stale payload; only mem_valid_o qualifies it.
- BPU update: upd_valid_o <= branch_flush_o, latency 1 cycle. upd_lane_o / upd_target_o are loaded only when branch_flush_o is high, else held.
- Reset: all outputs are 0 and served is 0. Reset mid-serialisation abandons the bundle; no dcache request is issued until reset releases.
- Combinational outputs (dc_*, pause_o, branch/excp flush) are 0 while rst is low.

Test Plan:
- 4 lanes valid, lanes 1 and 3 stores, addr_ok always 1 -> dc_vaddr_o shows lane1 then lane3 on consecutive cycles; pause_o=1 for 1 cycle; mem_valid_o=4'b1111 after completion.
- Lane 1 br_flush target 0x1C000040, lanes 2 and 3 valid with mem_req -> branch_flush_o=1, branch_target_o=0x1C000040, no dcache request from lanes 2 and 3, mem_valid_o=4'b0011, upd_valid_o=1 one cycle later with upd_lane_o=1.
- Lane 0 load with addr_ok held 0 for 3 cycles -> dc_valid_o held 3+1 cycles with constant address, pause_o high 3 cycles, one bubble per stalled cycle into mem.
- Lane 2 excp and mem_req, lane 0 load -> only lane 0 issues; excp_flush_o=1 on completion; mem_valid_o=4'b0111.
- flush asserted between two pending requests -> dc_valid_o=0 that cycle, served cleared, mem_valid_o=0; the next bundle restarts from its lowest lane.
- pause high while the bundle is complete -> outputs hold, no dcache re-issue, branch_flush_o gated to 0 until pause drops; rst asserted mid-stall -> all outputs 0 immediately.
